// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory or arbiter (slave).
// The master drives the request side and samples ack/rdata.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access with wait/timeout handling, load
// alignment/extension, writeback select and the MEM/WB register.
//
// state  | meaning
// S_IDLE | no access outstanding; a new access may be issued this cycle
// S_WAIT | access issued, ack not yet seen; bus held, wcnt counts waits
module mem_stage (
  input  logic        clk,
  input  logic        reset,

  input  logic        MEM_cntl_MemRead,
  input  logic        MEM_cntl_MemWrite,
  input  logic        MEM_cntl_RegWrite,
  input  logic [2:0]  MEM_sel_MemToReg,
  input  logic [2:0]  MEM_funct,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_WriteMemData,
  input  logic [4:0]  MEM_WriteRegNum,
  input  logic [31:0] MEM_immediate,
  input  logic [19:0] MEM_PCplus4,
  input  logic [19:0] MEM_BranchAddr,

  mem_stage_if.master dmem,

  output logic        MEM_stall,
  output logic        MEM_misaligned,
  output logic        MEM_bus_err,

  output logic        WB_cntl_RegWrite,
  output logic [4:0]  WB_WriteRegNum,
  output logic [31:0] WB_WriteData
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        post_rst_q;

  logic        access;
  logic        mis;
  logic        req;
  logic        stall;
  logic        timeout;
  logic        misal;
  logic        latch_en;

  logic [1:0]  lane;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] wb_data;

  assign access = MEM_cntl_MemRead | MEM_cntl_MemWrite;
  assign lane   = MEM_ALUResult[1:0];

  always_comb begin
    mis = 1'b0;
    if (access) begin
      case (MEM_funct[1:0])
        2'b01:   mis = lane[0];
        2'b10:   mis = (lane != 2'b00);
        2'b11:   mis = 1'b1;
        default: mis = 1'b0;
      endcase
    end
  end

  // Store data is replicated across lanes; reads always fetch the full word.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = 32'h0;
    if (MEM_cntl_MemWrite) begin
      case (MEM_funct[1:0])
        2'b00: begin
          be_new    = 4'b0001 << lane;
          wdata_new = {4{MEM_WriteMemData[7:0]}};
        end
        2'b01: begin
          be_new    = 4'b0011 << lane;
          wdata_new = {2{MEM_WriteMemData[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = MEM_WriteMemData;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 4'd0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      post_rst_q <= 1'b0;
    end
  end

  // The first cycle after reset is blanked so a stale access or late ack
  // cannot restart the bus.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    timeout = 1'b0;
    misal   = 1'b0;
    if (!post_rst_q) begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (mis) begin
              misal = 1'b1;
            end else begin
              req = 1'b1;
              if (!dmem.dmem_ack) begin
                stall   = 1'b1;
                state_d = S_WAIT;
                wcnt_d  = 4'd0;
              end
            end
          end
        end
        S_WAIT: begin
          req = 1'b1;
          if (dmem.dmem_ack) begin
            state_d = S_IDLE;
          end else if (wcnt_q == 4'd15) begin
            timeout = 1'b1;
            state_d = S_IDLE;
          end else begin
            stall  = 1'b1;
            wcnt_d = wcnt_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign latch_en = (state_q == S_IDLE) && (state_d == S_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else if (latch_en) begin
      we_q    <= MEM_cntl_MemWrite;
      addr_q  <= {MEM_ALUResult[31:2], 2'b00};
      be_q    <= be_new;
      wdata_q <= wdata_new;
    end
  end

  always_comb begin
    dmem.dmem_req   = req;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = 32'h0;
    dmem.dmem_be    = 4'h0;
    dmem.dmem_wdata = 32'h0;
    if (req) begin
      if (state_q == S_WAIT) begin
        dmem.dmem_we    = we_q;
        dmem.dmem_addr  = addr_q;
        dmem.dmem_be    = be_q;
        dmem.dmem_wdata = wdata_q;
      end else begin
        dmem.dmem_we    = MEM_cntl_MemWrite;
        dmem.dmem_addr  = {MEM_ALUResult[31:2], 2'b00};
        dmem.dmem_be    = be_new;
        dmem.dmem_wdata = wdata_new;
      end
    end
  end

  assign MEM_stall      = stall;
  assign MEM_misaligned = misal;
  assign MEM_bus_err    = timeout;

  always_comb begin
    ld_byte = 8'h0;
    case (lane)
      2'd0: ld_byte = dmem.dmem_rdata[7:0];
      2'd1: ld_byte = dmem.dmem_rdata[15:8];
      2'd2: ld_byte = dmem.dmem_rdata[23:16];
      2'd3: ld_byte = dmem.dmem_rdata[31:24];
      default: ld_byte = 8'h0;
    endcase
    ld_half = lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (MEM_funct)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    case (MEM_sel_MemToReg)
      3'b000:  wb_data = MEM_ALUResult;
      3'b001:  wb_data = ld_data;
      3'b010:  wb_data = MEM_immediate;
      3'b011:  wb_data = {12'h0, MEM_BranchAddr};
      3'b100:  wb_data = {12'h0, MEM_PCplus4};
      default: wb_data = 32'h0;
    endcase
  end

  // A stalled or blanked cycle retires a bubble and keeps the last WB payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      WB_cntl_RegWrite <= 1'b0;
      WB_WriteRegNum   <= 5'd0;
      WB_WriteData     <= 32'h0;
    end else if (stall || post_rst_q) begin
      WB_cntl_RegWrite <= 1'b0;
    end else begin
      WB_cntl_RegWrite <= MEM_cntl_RegWrite & ~MEM_cntl_MemWrite & ~mis & ~timeout;
      WB_WriteRegNum   <= MEM_WriteRegNum;
      WB_WriteData     <= wb_data;
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have a single clock and a reset that is synchronous and active-high: one clock; reset is synchronous and active-high.
REQ-002 SHALL have these clock and reset ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have these pipeline-register inputs:
- MEM_cntl_MemRead  in  1  load request.
- MEM_cntl_MemWrite  in  1  store request.
- MEM_cntl_RegWrite  in  1  writeback enable.
- MEM_sel_MemToReg  in  3  writeback source select.
- MEM_funct  in  3  access width/sign.
- MEM_ALUResult  in  32  byte address or ALU result.
- MEM_WriteMemData  in  32  store data.
- MEM_WriteRegNum  in  5  destination register.
- MEM_immediate  in  32  immediate.
- MEM_PCplus4  in  20  PC + 4.
- MEM_BranchAddr  in  20  branch target.
REQ-004 SHALL have these data-memory bus ports:
- dmem_req  out  1  access request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word-aligned byte address {MEM_ALUResult[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  access complete.
- dmem_rdata  in  32  read word.
REQ-005 SHALL have these status outputs:
- MEM_stall  out  1  upstream hold request; the EX/MEM register and earlier stages freeze while it is high.
- MEM_misaligned  out  1  one-cycle misalignment pulse.
- MEM_bus_err  out  1  one-cycle timeout pulse.
REQ-006 SHALL have these registered MEM/WB outputs:
- WB_cntl_RegWrite  out  1  writeback enable.
- WB_WriteRegNum  out  5  destination register.
- WB_WriteData  out  32  writeback data.

Function
REQ-007 SHALL implement a 2-state FSM, IDLE and WAIT, plus a 4-bit wait counter wcnt.
REQ-008 SHALL define access = MemRead|MemWrite.
REQ-009 SHALL define the misalignment condition mis as follows, evaluated only while access=1:
- funct[1:0]=01 with addr[0]=1.
- funct[1:0]=10 with addr[1:0]!=00.
- funct[1:0]=11.
REQ-010 SHALL drive dmem_req=1 when (IDLE & access & !mis) or WAIT, and dmem_we=MemWrite while dmem_req=1; all bus outputs SHALL be 0 when dmem_req=0.
REQ-011 SHALL generate byte enables as follows:
- SB: be=0001<<addr[1:0], wdata={4{data[7:0]}}.
- SH: be=0011<<addr[1:0], wdata={2{data[15:0]}}.
- SW: be=1111, wdata=data.
- Reads: be=1111.
REQ-012 SHALL hold all bus outputs stable while in WAIT.
REQ-013 SHALL treat dmem_ack as valid only when dmem_req=1; ack with req=0 SHALL be ignored.
REQ-014 SHALL combinationally assert MEM_stall when dmem_req=1 & dmem_ack=0, and deassert it in the cycle ack arrives (zero-wait access = no stall).
REQ-015 SHALL make the following FSM transitions:
- IDLE -> WAIT on req & !ack, with wcnt cleared to 0.
- WAIT -> IDLE on ack.
- WAIT -> IDLE when wcnt=15 & !ack (timeout).
- wcnt increments each WAIT cycle without ack.
REQ-016 SHALL, on timeout, pulse MEM_bus_err for one cycle, drop MEM_stall that cycle, and retire the instruction with WB_cntl_RegWrite=0.
REQ-017 SHALL treat a misaligned access as follows:
- No bus request.
- MEM_misaligned=1 for that cycle.
- No stall.
- Retire with WB_cntl_RegWrite=0.
- Stores are suppressed.
REQ-018 SHALL extract load data as follows, with lane = addr[1:0]:
- LB (000): sign-extend rdata byte[lane].
- LH (001): sign-extend rdata half[addr[1]].
- LW (010): rdata.
- LBU (100): zero-extend the byte.
- LHU (101): zero-extend the half.
REQ-019 SHALL select writeback data as follows:
- sel 000: ALUResult.
- sel 001: load data.
- sel 010: immediate.
- sel 011: {12'b0,BranchAddr}.
- sel 100: {12'b0,PCplus4}.
- sel 101-111: 0.
REQ-020 SHALL update the MEM/WB registers on every rising edge:
- If MEM_stall=1, insert a bubble (WB_cntl_RegWrite=0, other WB outputs hold).
- Otherwise capture RegWrite (gated by !mis & !timeout), WriteRegNum and the REQ-019 data.
REQ-021 SHALL give a non-memory instruction 1-cycle latency, and a memory instruction 1 + (wait cycles) latency.
REQ-022 SHALL, on a store, write no register regardless of RegWrite; WB_cntl_RegWrite=RegWrite & !MemWrite.
REQ-023 SHALL, if MemRead and MemWrite are both 1, treat the access as a store and force WB_cntl_RegWrite=0.

Reset
REQ-024 SHALL, with reset=1 at a rising edge:
- Set the FSM to IDLE.
- Set wcnt=0.
- Set WB_cntl_RegWrite=0, WB_WriteRegNum=0, WB_WriteData=0.
REQ-025 SHALL force dmem_req=0, MEM_stall=0, MEM_misaligned=0 and MEM_bus_err=0 in the cycle after reset, even if reset occurred in WAIT; a late ack SHALL then be ignored.

Verification
REQ-026 SHALL be covered by a directed test for a zero-wait LW: addr=0x100, ack same cycle, rdata=0xDEADBEEF, rd=5 -> no stall; next edge WB_RegWrite=1, WB_WriteRegNum=5, WB_WriteData=0xDEADBEEF.
REQ-027 SHALL be covered by a directed test for a waited LB: addr=0x103, rdata=0x80xxxxxx, ack after 3 cycles -> MEM_stall=1 for 3 cycles with WB bubbles; then WB_WriteData=0xFFFFFF80 (LBU: 0x00000080).
REQ-028 SHALL be covered by a directed test for SH: addr=0x22, data=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, WB_RegWrite=0.
REQ-029 SHALL be covered by a directed test for a misaligned LW: addr=0x101 -> dmem_req=0, MEM_misaligned=1 for one cycle, WB_RegWrite=0, no stall.
REQ-030 SHALL be covered by a directed test for a timeout: no ack for 16 WAIT cycles -> MEM_bus_err=1 for one cycle, stall released, WB_RegWrite=0; then a reset asserted mid-WAIT in a separate run -> dmem_req=0 next cycle, and a subsequent ack has no effect.
REQ-031 SHALL be covered by a directed test for writeback selects 011/100: BranchAddr=0xABCDE, PCplus4=0x00104 -> WB_WriteData=0x000ABCDE and 0x00000104 respectively, each with 1-cycle latency.
